exc_sequencer: RTL and testbench



---
 rtl/exc_sequencer.sv | 89 ++++++++
 tb/tb_exc_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// exc_sequencer: latches and prioritises exception sources, holds Exc/EStatus until ExcAck,
// masks nesting while the handler runs, and sequences ERet and the ExtIAck handshake.
module exc_sequencer #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ExtIRQ,
    input  logic       InvOp,
    input  logic       ERetDec,
    input  logic       ExcAck,
    output logic       Exc,
    output logic [3:0] EStatus,
    output logic       ERet,
    output logic       ExtIAck,
    output logic       InHandler,
    output logic       AckTimeout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HND  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev, r_pend, r_src;
    logic             r_exc, r_eret, r_iack, r_inh, r_tmo;
    logic [3:0]       r_cause;
    logic             w_edge;

    assign w_edge     = ExtIRQ & ~r_prev;
    assign Exc        = r_exc;
    assign EStatus    = r_cause;
    assign ERet       = r_eret;
    assign ExtIAck    = r_iack;
    assign InHandler  = r_inh;
    assign AckTimeout = r_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b0;
            r_pend  <= 1'b0;
            r_src   <= 1'b0;
            r_exc   <= 1'b0;
            r_eret  <= 1'b0;
            r_iack  <= 1'b0;
            r_inh   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cause <= 4'b0000;
        end else begin
            r_prev <= ExtIRQ;
            r_pend <= r_pend | w_edge;
            r_eret <= 1'b0;
            r_iack <= 1'b0;
            case (r_state)
                S_IDLE: if (InvOp | ERetDec | r_pend) begin
                    r_state <= S_REQ;
                    r_exc   <= 1'b1;
                    r_cause <= InvOp ? 4'b0010 : ERetDec ? 4'b0011 : 4'b0001;
                    r_src   <= ~InvOp & ~ERetDec;
                end
                S_REQ: if (ExcAck) begin
                    r_state <= S_HND;
                    r_exc   <= 1'b0;
                    r_inh   <= 1'b1;
                    r_cnt   <= '0;
                    // a fresh edge in the acknowledge cycle survives the clear
                    if (r_src) begin
                        r_iack <= 1'b1;
                        r_pend <= w_edge;
                        r_src  <= 1'b0;
                    end
                end else if (r_cnt != CNT_W'(ACK_TIMEOUT)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(ACK_TIMEOUT - 1))
                        r_tmo <= 1'b1;
                end
                S_HND: if (ERetDec) begin
                    r_state <= S_IDLE;
                    r_eret  <= 1'b1;
                    r_inh   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed vector table, timeout sequence and randomized run against a cycle model.
module tb_exc_sequencer;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset, ExtIRQ, InvOp, ERetDec, ExcAck;
    logic       Exc, ERet, ExtIAck, InHandler, AckTimeout;
    logic [3:0] EStatus;

    int checks = 0;
    int errors = 0;

    exc_sequencer #(.ACK_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .InvOp(InvOp), .ERetDec(ERetDec),
        .ExcAck(ExcAck), .Exc(Exc), .EStatus(EStatus), .ERet(ERet), .ExtIAck(ExtIAck),
        .InHandler(InHandler), .AckTimeout(AckTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, irq, inv, er, ack;
        logic       exc;
        logic [3:0] es;
        logic       ret, iak, inh, tmo;
    } vec_t;

    // model: mode 0 = waiting, 1 = request outstanding, 2 = handler running
    int         m_mode, m_wait;
    logic       m_prev, m_pend, m_irqsrc;
    logic       m_exc, m_ret, m_iak, m_inh, m_tmo;
    logic [3:0] m_es;

    task automatic model_step();
        logic e;
        if (reset) begin
            m_mode = 0; m_wait = 0; m_prev = 0; m_pend = 0; m_irqsrc = 0;
            m_exc = 0; m_ret = 0; m_iak = 0; m_inh = 0; m_tmo = 0; m_es = 0;
            return;
        end
        e = ExtIRQ & ~m_prev;
        m_prev = ExtIRQ;
        m_ret = 0;
        m_iak = 0;
        if (m_mode == 0) begin
            if (InvOp || ERetDec || m_pend) begin
                m_mode = 1;
                m_exc = 1;
                m_es = InvOp ? 4'd2 : ERetDec ? 4'd3 : 4'd1;
                m_irqsrc = !InvOp && !ERetDec;
            end
            m_pend = m_pend | e;
        end else if (m_mode == 1) begin
            if (ExcAck) begin
                m_mode = 2; m_exc = 0; m_inh = 1; m_wait = 0;
                if (m_irqsrc) begin m_iak = 1; m_irqsrc = 0; m_pend = e; end
                else m_pend = m_pend | e;
            end else begin
                m_wait = (m_wait < TMO) ? m_wait + 1 : TMO;
                if (m_wait == TMO) m_tmo = 1;
                m_pend = m_pend | e;
            end
        end else begin
            if (ERetDec) begin m_mode = 0; m_ret = 1; m_inh = 0; end
            m_pend = m_pend | e;
        end
    endtask

    task automatic step(input logic r, input logic i, input logic v, input logic d, input logic a);
        reset = r; ExtIRQ = i; InvOp = v; ERetDec = d; ExcAck = a;
        @(posedge clk);
        #1;
        model_step();
    endtask

    function automatic logic [8:0] outs();
        return {Exc, EStatus, ERet, ExtIAck, InHandler, AckTimeout};
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1,1,1,0,0, 0,4'h0,0,0,0,0};
        tbl[1]  = '{1,1,1,0,0, 0,4'h0,0,0,0,0};
        tbl[2]  = '{1,1,1,0,0, 0,4'h0,0,0,0,0};
        tbl[3]  = '{0,1,1,0,0, 1,4'h2,0,0,0,0};
        tbl[4]  = '{0,1,0,0,0, 1,4'h2,0,0,0,0};
        tbl[5]  = '{0,1,0,0,1, 0,4'h2,0,0,1,0};
        tbl[6]  = '{0,1,1,0,0, 0,4'h2,0,0,1,0};
        tbl[7]  = '{0,1,0,1,0, 0,4'h2,1,0,0,0};
        tbl[8]  = '{0,1,0,0,0, 1,4'h1,0,0,0,0};
        tbl[9]  = '{0,1,0,0,1, 0,4'h1,0,1,1,0};
        tbl[10] = '{0,1,0,0,0, 0,4'h1,0,0,1,0};
        tbl[11] = '{0,1,0,1,0, 0,4'h1,1,0,0,0};
        tbl[12] = '{0,1,0,0,0, 0,4'h1,0,0,0,0};
        tbl[13] = '{0,1,0,1,0, 1,4'h3,0,0,0,0};
        tbl[14] = '{0,1,0,0,1, 0,4'h3,0,0,1,0};
        tbl[15] = '{0,0,0,0,0, 0,4'h3,0,0,1,0};
        tbl[16] = '{0,0,0,1,0, 0,4'h3,1,0,0,0};
        reset = 1; ExtIRQ = 0; InvOp = 0; ERetDec = 0; ExcAck = 0;
        #2;
        for (int k = 0; k < 17; k++) begin
            step(tbl[k].rst, tbl[k].irq, tbl[k].inv, tbl[k].er, tbl[k].ack);
            chk($sformatf("vec%0d", k), outs(),
                {tbl[k].exc, tbl[k].es, tbl[k].ret, tbl[k].iak, tbl[k].inh, tbl[k].tmo});
        end

        // masked edge and InvOp while in handler, pending IRQ taken after return
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("hnd_entry", outs(), {1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0});
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("hnd_masked", outs(), {1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0});
        step(0, 1, 0, 1, 0);
        chk("hnd_eret", outs(), {1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0});
        step(0, 1, 0, 0, 0);
        chk("irq_after_ret", outs(), {1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0});

        // acknowledge timeout: sticky through handler and return, cleared by reset
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 0, 0);
            if (k == 15 || k == 16 || k == 20)
                chk($sformatf("tmo_wait%0d", k), outs(),
                    {1'b1, 4'h2, 1'b0, 1'b0, 1'b0, logic'(k >= TMO)});
        end
        step(0, 0, 0, 0, 1);
        chk("tmo_late_ack", outs(), {1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1});
        step(0, 0, 0, 1, 0);
        chk("tmo_sticky", outs(), {1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1});
        step(1, 0, 0, 0, 0);
        chk("tmo_reset", outs(), 9'h000);

        // randomized traffic against the model
        begin
            logic irq = 0;
            int ack_div;
            for (int k = 0; k < 4000; k++) begin
                ack_div = ((k / 500) % 2 == 1) ? 40 : 4;
                if ($urandom_range(7) == 0) irq = ~irq;
                step(logic'($urandom_range(299) == 0), irq,
                     logic'($urandom_range(9) == 0), logic'($urandom_range(5) == 0),
                     logic'($urandom_range(ack_div - 1) == 0));
                chk("rand", outs(), {m_exc, m_es, m_ret, m_iak, m_inh, m_tmo});
                chk("excl", {7'd0, ExtIAck & ERet, Exc & InHandler}, 9'h000);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
